ram8_master: RTL and testbench

//  Initiator for the 8x16 synchronous RAM port (addr / data_in / we in, data_out registered out).

---
 rtl/ram8_master.sv | 126 ++++++++++++
 tb/tb_ram8_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram8_master.sv
// Burst initiator for the 8x16 synchronous RAM port. It accepts one write or read burst command,
// then steps the beats onto the RAM port, applying backpressure on write data and read responses.
module ram8_master #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic          wdata_valid,
    output logic          wdata_ready,
    input  logic [DW-1:0] wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdIssue,
        StRdCap,
        StRdHold,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_valid_q, rsp_valid_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        mem_we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    state_d = cmd_we ? StWr : StRdIssue;
                end
            end
            StWr: begin
                wdata_ready = 1'b1;
                // Gating with reset_n keeps the RAM untouched on an aborting reset edge.
                mem_we      = wdata_valid & reset_n;
                if (wdata_valid) begin
                    if (cnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        cnt_d  = cnt_q - 1'b1;
                    end
                end
            end
            StRdIssue: begin
                state_d = StRdCap;
            end
            StRdCap: begin
                rsp_data_d  = mem_rdata;
                rsp_valid_d = 1'b1;
                state_d     = StRdHold;
            end
            StRdHold: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (cnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        cnt_d   = cnt_q - 1'b1;
                        state_d = StRdIssue;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ram8_master.sv
// Bench for ram8_master: a read-first RAM model on the memory port, a word-level reference memory,
// and a scoreboard that checks every RAM write and every read response as the DUT emits it.
module tb_ram8_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [2:0]  cmd_addr = '0;
    logic [2:0]  cmd_len = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [15:0] wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic        busy;
    logic        done;
    logic [2:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;

    ram8_master #(.DW(16), .AW(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Read-first 8x16 RAM with active-high output reset driven as ~reset_n.
    logic [15:0] ram [8];
    always @(posedge clk) begin
        if (!reset_n) begin
            mem_rdata <= '0;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [15:0] ref_mem [8];
    logic [15:0] wd [8];
    int          n_chk = 0;
    int          n_pass = 0;
    int          done_cnt = 0;
    int          bursts = 0;
    int          rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic note_fail(input string name);
        n_chk++;
        $display("FAIL %s: got unexpected event, expected none at %0t", name, $time);
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: rsp_ready = 1'b1;
            1: rsp_ready = 1'($urandom_range(1, 0));
            default: rsp_ready = 1'b0;
        endcase
    end

    // Scoreboard monitor
    wr_t         mw;
    logic [15:0] mr;
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    note_fail("wr_extra");
                end else begin
                    mw = exp_wr.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(mw.a));
                    chk("wr_data", 32'(mem_wdata), 32'(mw.d));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rd.size() == 0) begin
                    note_fail("rd_extra");
                end else begin
                    mr = exp_rd.pop_front();
                    chk("rd_data", 32'(rsp_data), 32'(mr));
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic issue_cmd(input logic we, input int a, input int len);
        int t = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = 3'(a);
        cmd_len   = 3'(len);
        do begin
            @(negedge clk);
            t++;
        end while (!cmd_ready && t < 50);
        if (!cmd_ready) chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        // Junk on the command bus while busy must be ignored.
        cmd_valid = 1'b0;
        cmd_we    = 1'($urandom);
        cmd_addr  = 3'($urandom);
        cmd_len   = 3'($urandom);
    endtask

    task automatic wait_done(input int max);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < max);
        chk("done_seen", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        bursts++;
        chk("done_once", 32'(done_cnt), 32'(bursts));
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    // gap < 0: random 0..3 idle cycles before every beat; gap >= 0: fixed gap between beats.
    task automatic run_write(input int a, input int len, input int gap, input int abort_beat);
        int n = (abort_beat >= 0) ? abort_beat : len + 1;
        for (int i = 0; i < n; i++) begin
            exp_wr.push_back('{a: 3'((a + i) % 8), d: wd[i]});
            ref_mem[(a + i) % 8] = wd[i];
        end
        issue_cmd(1'b1, a, len);
        for (int i = 0; i <= len; i++) begin
            int g = (gap < 0) ? int'($urandom_range(3, 0)) : ((i > 0) ? gap : 0);
            wdata_valid = 1'b0;
            repeat (g) begin
                @(negedge clk);
                chk("gap_no_we", 32'(mem_we), 32'd0);
                chk("gap_cmd_ready", 32'(cmd_ready), 32'd0);
                @(posedge clk);
                #1;
            end
            wdata_valid = 1'b1;
            wdata       = wd[i];
            if (i == abort_beat) begin
                reset_n = 1'b0;
                @(negedge clk);
                chk("rst_no_we", 32'(mem_we), 32'd0);
                @(posedge clk);
                #1;
                wdata_valid = 1'b0;
                @(negedge clk);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_wready", 32'(wdata_ready), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_addr", 32'(mem_addr), 32'd0);
                @(posedge clk);
                #1;
                reset_n = 1'b1;
                @(negedge clk);
                chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
                chk("rst_no_done", 32'(done_cnt), 32'(bursts));
                @(posedge clk);
                #1;
                return;
            end
            begin
                int t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!wdata_ready && t < 50);
                chk("wr_beat_taken", 32'(wdata_ready), 32'd1);
            end
            @(posedge clk);
            #1;
        end
        wdata_valid = 1'b0;
        wait_done(1);
    endtask

    task automatic run_read(input int a, input int len, input int hold);
        for (int i = 0; i <= len; i++) exp_rd.push_back(ref_mem[(a + i) % 8]);
        issue_cmd(1'b0, a, len);
        @(negedge clk);
        chk("rd_lat1", 32'(rsp_valid), 32'd0);
        chk("rd_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("rd_lat2", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("rd_lat3", 32'(rsp_valid), 32'd1);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_addr", 32'(mem_addr), 32'(a));
            chk("hold_no_done", 32'(done), 32'd0);
        end
        rdy_mode = 0;
        wait_done(100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_wready", 32'(wdata_ready), 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Write burst with wrap, then read it back
        wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h4444;
        run_write(6, 3, 0, -1);
        rdy_mode = 0;
        run_read(6, 3, 0);

        // Backpressure on a single beat at addr 7
        rdy_mode = 2;
        run_read(7, 0, 5);

        // Write stall between beats
        wd[0] = 16'hA5A5; wd[1] = 16'h5A5A;
        run_write(3, 1, 2, -1);

        // Reset during the third beat of an 8-beat write
        for (int k = 0; k < 8; k++) wd[k] = 16'($urandom);
        run_write(1, 7, 0, 2);

        // Full sweep
        for (int k = 0; k < 8; k++) wd[k] = 16'(k * 16'h0101);
        run_write(0, 7, 0, -1);
        run_read(5, 7, 0);

        // Randomized bursts
        for (int n = 0; n < 40; n++) begin
            int a   = int'($urandom_range(7, 0));
            int len = int'($urandom_range(7, 0));
            if ($urandom_range(1, 0) == 1) begin
                for (int k = 0; k < 8; k++) wd[k] = 16'($urandom);
                run_write(a, len, -1, -1);
            end else begin
                rdy_mode = 1;
                run_read(a, len, 0);
            end
        end

        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
